// File: rtl/w0rm_stopwatch.sv
// ============================================================================
// Module   : w0rm_stopwatch
// Purpose  : Interval measurement. A start pulse arms a cycle counter, a later
//            stop pulse captures the number of clock edges between the two
//            sampling edges. The result is held behind a valid/ack handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH    counter / result width in bits (>= 2)
//   TIMEOUT  abort limit in cycles (1 .. 2^WIDTH-1), used only when the
//            macro W0RM_STOPWATCH_TIMEOUT_EN is defined
// Ports
//   clk           in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   start         in   begin measurement (level sampled)
//   stop          in   end measurement (level sampled)
//   result_ack    in   consumer accepts the held result
//   busy          out  measurement in progress
//   result        out  measured cycle count, valid with result_valid
//   result_valid  out  result held until result_ack
//   overflow      out  count saturated, qualified by result_valid
//   timeout       out  measurement aborted by TIMEOUT, qualified by result_valid
// Configuration macro
//   W0RM_STOPWATCH_TIMEOUT_EN  enables the TIMEOUT abort; otherwise timeout=0
// ============================================================================
`default_nettype none

module w0rm_stopwatch #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             result_ack,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             overflow,
  output logic             timeout
);

  // State bits double as the busy / result_valid outputs, so both come
  // straight from flops with no decode logic.
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam logic [WIDTH-1:0] C_MAX = '1;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_result;
  logic             r_ovf;
  logic             r_tmo;
  logic [WIDTH-1:0] w_cnt_inc;
  logic             w_hit_tmo;
  logic             w_end;

  // Saturating increment; the captured result is this value on the stop
  // edge, which makes result equal to the edge distance start->stop.
  assign w_cnt_inc = (r_count == C_MAX) ? C_MAX : (r_count + WIDTH'(1));

`ifdef W0RM_STOPWATCH_TIMEOUT_EN
  localparam logic [WIDTH-1:0] C_TIMEOUT = WIDTH'(TIMEOUT);
  assign w_hit_tmo = (w_cnt_inc == C_TIMEOUT);
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT != 0);
  assign w_hit_tmo = 1'b0;
`endif

  assign w_end = stop | w_hit_tmo;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------- next-state comb
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)      w_state_nxt = S_RUN;
      S_RUN:   if (w_end)      w_state_nxt = S_DONE;
      S_DONE:  if (result_ack) w_state_nxt = S_IDLE;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count  <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_tmo   <= 1'b0;
          end
        end
        S_RUN: begin
          r_count <= w_cnt_inc;
          if (w_cnt_inc == C_MAX) begin
            r_ovf <= 1'b1;
          end
          if (w_end) begin
            r_result <= w_cnt_inc;
            // A stop on the timeout edge is a normal completion.
            r_tmo    <= ~stop & w_hit_tmo;
          end
        end
        S_DONE: begin
          if (result_ack) begin
            r_ovf <= 1'b0;
            r_tmo <= 1'b0;
          end
        end
        default: begin
          r_count <= '0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------- output comb
  always_comb begin
    busy         = r_state[0];
    result_valid = r_state[1];
    result       = r_result;
    overflow     = r_ovf;
    timeout      = r_tmo;
  end

endmodule

`default_nettype wire

// File: doc/w0rm_stopwatch.md
# w0rm_stopwatch

Interval-measurement block: the counterpart of the static timer. The static timer turns a start pulse into a stop pulse after a fixed count; this block receives a start pulse and a later stop pulse and reports the number of clock cycles between them. It is used to measure latencies of core-side handshakes and to self-check timer instances in-system. The result is held behind a valid/ack handshake until consumed.

## Interface
- WIDTH, 16: counter and result width in bits (min 2).
- TIMEOUT, 1000: abort limit in cycles; only used when W0RM_STOPWATCH_TIMEOUT_EN is defined; must be 1..2^WIDTH-1.

- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin measurement; sampled on rising edge.
- stop  in  1  end measurement; sampled on rising edge.
- busy  out  1  high while measuring (RUNNING).
- result  out  WIDTH  measured cycle count; valid only while result_valid.
- result_valid  out  1  result available; held until acknowledged.
- result_ack  in  1  consumer accepts result.
- overflow  out  1  count saturated before stop; qualified by result_valid.
- timeout  out  1  measurement aborted by TIMEOUT; qualified by result_valid.

## Operation
- States: IDLE, RUNNING, DONE.
- IDLE: start=1 -> RUNNING, count <= 0. stop ignored. result_ack ignored.
- RUNNING: each cycle count <= count+1, saturating at 2^WIDTH-1; reaching 2^WIDTH-1 sets overflow sticky for this measurement.
- RUNNING, stop=1: result <= saturating count+1, -> DONE. start ignored while RUNNING (no restart).
- DONE: result_valid=1, result/overflow/timeout stable. result_ack=1 -> IDLE, clears result_valid, overflow, timeout. start ignored in DONE, including the ack cycle.
- Result definition: start sampled on edge N, stop on edge M -> result = M-N (min 1).
- start and stop high on same edge in IDLE: start accepted, stop ignored; measurement continues.
- stop and start high on same edge in RUNNING: stop taken, start ignored.
- Reset mid-operation: immediate return to IDLE, measurement discarded, no result produced.
- start/stop are level-sampled; a held start re-arms immediately after ack+1 (IDLE sees it next edge).

## Timing
- Reset values: busy=0, result=0, result_valid=0, overflow=0, timeout=0; state IDLE, count 0.
- busy rises the cycle after start is sampled; falls with result_valid rising (same edge stop is sampled).
- Start-to-busy latency 1 cycle; stop-to-result_valid latency 1 cycle (registered outputs).
- result_valid falls the cycle after result_ack sampled; earliest next start accepted the edge after that.
- Min measurement period (start edge to next accepted start edge): result+2 cycles.
- All outputs registered; no combinational input-to-output path.

## Configuration
- W0RM_STOPWATCH_TIMEOUT_EN defined: in RUNNING, if count+1 reaches TIMEOUT with no stop, -> DONE with result=TIMEOUT, timeout=1; a stop on that same edge wins (timeout=0, result=TIMEOUT). overflow cannot occur if TIMEOUT < 2^WIDTH-1.
- Not defined: no abort; measurement runs until stop, saturating; timeout output tied 0; TIMEOUT unused.

## Test plan
- Reset: hold reset_n=0, toggle start/stop -> all outputs 0, no result_valid; release -> still IDLE.
- Basic: start on edge 10, stop on edge 17 -> result=7, result_valid on edge 17, held until ack; ack -> result_valid=0 next edge.
- Simultaneous/ignored: start+stop same edge in IDLE, stop 12 edges later -> result=12; extra start mid-run and stop in DONE -> no effect; start during ack cycle ignored.
- Overflow (WIDTH=4, macro off): stop 20 cycles after start -> result=15, overflow=1; ack clears overflow.
- Timeout (macro on, TIMEOUT=5): start, no stop -> result_valid 5 cycles after start, result=5, timeout=1; stop exactly at cycle 5 -> result=5, timeout=0.
- Reset mid-run: start, 3 cycles later reset_n=0 asynchronously -> busy=0 immediately, no result after release.
